// File: rtl/bip_control_unit.sv
// bip_control_unit: three-cycle fetch/decode/execute controller for the 16-bit
// accumulator datapath. Every output is a register. The instruction word is sampled
// only into registers, so there is no combinational path from i_instr to an output.
module bip_control_unit #(
  parameter int PC_WIDTH    = 11,
  parameter int OP_WIDTH    = 5,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  output logic [PC_WIDTH-1:0]    o_pc,
  output logic [OP_WIDTH-1:0]    o_op,
  output logic [PC_WIDTH-1:0]    o_operand,
  output logic [1:0]             o_sel_a,
  output logic                   o_sel_b,
  output logic                   o_wr_acc,
  output logic                   o_rd_ram,
  output logic                   o_wr_ram,
  output logic                   o_busy,
  output logic                   o_halt,
  output logic                   o_illegal
);

  localparam logic [OP_WIDTH-1:0] OP_HLT  = 5'b00000;
  localparam logic [OP_WIDTH-1:0] OP_STO  = 5'b00001;
  localparam logic [OP_WIDTH-1:0] OP_LD   = 5'b00010;
  localparam logic [OP_WIDTH-1:0] OP_LDI  = 5'b00011;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 5'b00100;
  localparam logic [OP_WIDTH-1:0] OP_ADDI = 5'b00101;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 5'b00110;
  localparam logic [OP_WIDTH-1:0] OP_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                state_q;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [OP_WIDTH-1:0]   op_q;
  logic [PC_WIDTH-1:0]   operand_q;
  logic [1:0]            sel_a_q;
  logic                  sel_b_q, wr_acc_q, rd_ram_q, wr_ram_q;
  logic                  busy_q, halt_q, illegal_q;

  // Fields of the word arriving from program memory during DECODE.
  logic [OP_WIDTH-1:0]   instr_op_d;
  logic [PC_WIDTH-1:0]   instr_operand_d;
  logic [1:0]            sel_a_d;
  logic                  sel_b_d, wr_acc_d, rd_ram_d, wr_ram_d, illegal_d;

  assign instr_op_d      = i_instr[INSTR_WIDTH-1 -: OP_WIDTH];
  assign instr_operand_d = i_instr[PC_WIDTH-1:0];
  assign pc_d            = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

  // Decode the incoming opcode into the EXEC-cycle control word.
  always_comb begin
    sel_a_d   = 2'b00;
    sel_b_d   = 1'b0;
    wr_acc_d  = 1'b0;
    rd_ram_d  = 1'b0;
    wr_ram_d  = 1'b0;
    illegal_d = 1'b0;
    case (instr_op_d)
      OP_HLT: begin
        illegal_d = 1'b0;
      end
      OP_STO: begin
        wr_ram_d = 1'b1;
      end
      OP_LD: begin
        sel_a_d  = 2'b00;
        rd_ram_d = 1'b1;
        wr_acc_d = 1'b1;
      end
      OP_LDI: begin
        sel_a_d  = 2'b01;
        wr_acc_d = 1'b1;
      end
      OP_ADD, OP_SUB: begin
        sel_a_d  = 2'b10;
        sel_b_d  = 1'b0;
        rd_ram_d = 1'b1;
        wr_acc_d = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        sel_a_d  = 2'b10;
        sel_b_d  = 1'b1;
        wr_acc_d = 1'b1;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase
  end

  // Controller FSM with registered outputs; strobes are cleared every cycle
  // unless the cycle being entered is EXEC.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      op_q      <= '0;
      operand_q <= '0;
      sel_a_q   <= 2'b00;
      sel_b_q   <= 1'b0;
      wr_acc_q  <= 1'b0;
      rd_ram_q  <= 1'b0;
      wr_ram_q  <= 1'b0;
      busy_q    <= 1'b0;
      halt_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      sel_a_q   <= 2'b00;
      sel_b_q   <= 1'b0;
      wr_acc_q  <= 1'b0;
      rd_ram_q  <= 1'b0;
      wr_ram_q  <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_FETCH;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          // Capture IR and the control word that is shown during EXEC.
          state_q   <= S_EXEC;
          op_q      <= instr_op_d;
          operand_q <= instr_operand_d;
          sel_a_q   <= sel_a_d;
          sel_b_q   <= sel_b_d;
          wr_acc_q  <= wr_acc_d;
          rd_ram_q  <= rd_ram_d;
          wr_ram_q  <= wr_ram_d;
          illegal_q <= illegal_d;
        end
        S_EXEC: begin
          if (op_q == OP_HLT) begin
            state_q <= S_HALT;
            busy_q  <= 1'b0;
            halt_q  <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            pc_q    <= pc_d;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          halt_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pc      = pc_q;
  assign o_op      = op_q;
  assign o_operand = operand_q;
  assign o_sel_a   = sel_a_q;
  assign o_sel_b   = sel_b_q;
  assign o_wr_acc  = wr_acc_q;
  assign o_rd_ram  = rd_ram_q;
  assign o_wr_ram  = wr_ram_q;
  assign o_busy    = busy_q;
  assign o_halt    = halt_q;
  assign o_illegal = illegal_q;

endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: directed programs plus randomized programs, resets and
// start pulses, all checked cycle by cycle against an instruction-level model.
module tb_bip_control_unit;

  logic        clk = 1'b0;
  logic        i_reset, i_start;
  logic [15:0] i_instr;
  logic [10:0] o_pc, o_operand;
  logic [4:0]  o_op;
  logic [1:0]  o_sel_a;
  logic        o_sel_b, o_wr_acc, o_rd_ram, o_wr_ram, o_busy, o_halt, o_illegal;

  always #5 clk = ~clk;

  bip_control_unit dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_instr(i_instr),
    .o_pc(o_pc), .o_op(o_op), .o_operand(o_operand), .o_sel_a(o_sel_a),
    .o_sel_b(o_sel_b), .o_wr_acc(o_wr_acc), .o_rd_ram(o_rd_ram),
    .o_wr_ram(o_wr_ram), .o_busy(o_busy), .o_halt(o_halt), .o_illegal(o_illegal)
  );

  logic [15:0] rom [0:2047];
  logic [10:0] prev_pc;
  int n_checks = 0;
  int n_errors = 0;
  int wr_acc_cnt, wr_ram_cnt, ill_cnt;

  // Instruction-level model: mode 0 idle, 1 running, 2 halted; phase counts the
  // three cycles of an instruction (0 fetch, 1 decode, 2 execute).
  int m_mode, m_phase, m_pc, m_op, m_opr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ins(input int op, input int opr);
    logic [4:0]  o5;
    logic [10:0] a11;
    o5  = op[4:0];
    a11 = opr[10:0];
    return {o5, a11};
  endfunction

  task automatic model_step(input logic rst, input logic st);
    logic [15:0] w;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_pc = 0; m_op = 0; m_opr = 0;
    end else if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_phase = 0; end
    end else if (m_mode == 1) begin
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        w = rom[m_pc];
        m_op = int'(w[15:11]);
        m_opr = int'(w[10:0]);
        m_phase = 2;
      end else if (m_op == 0) m_mode = 2;
      else begin
        m_pc = (m_pc + 1) % 2048;
        m_phase = 0;
      end
    end
  endtask

  task automatic compare_all();
    bit ex, is_ld, is_ldi, is_alu;
    ex     = (m_mode == 1) && (m_phase == 2);
    is_ld  = (m_op == 2);
    is_ldi = (m_op == 3);
    is_alu = (m_op >= 4) && (m_op <= 7);
    check_eq("pc", 32'(o_pc), 32'(m_pc));
    check_eq("op", 32'(o_op), 32'(m_op));
    check_eq("operand", 32'(o_operand), 32'(m_opr));
    check_eq("busy", 32'(o_busy), 32'(m_mode == 1));
    check_eq("halt", 32'(o_halt), 32'(m_mode == 2));
    check_eq("wr_acc", 32'(o_wr_acc), 32'(ex && (is_ld || is_ldi || is_alu)));
    check_eq("wr_ram", 32'(o_wr_ram), 32'(ex && m_op == 1));
    check_eq("rd_ram", 32'(o_rd_ram), 32'(ex && (is_ld || m_op == 4 || m_op == 6)));
    check_eq("illegal", 32'(o_illegal), 32'(ex && m_op >= 8));
    check_eq("sel_a", 32'(o_sel_a), !ex ? 32'd0 : is_alu ? 32'd2 : is_ldi ? 32'd1 : 32'd0);
    check_eq("sel_b", 32'(o_sel_b), 32'(ex && is_alu && (m_op % 2 == 1)));
  endtask

  // One clock: apply inputs, model the edge, check #1 later, then present the
  // program-memory word addressed during the previous cycle (synchronous ROM).
  task automatic step(input logic rst, input logic st);
    i_reset = rst;
    i_start = st;
    @(posedge clk);
    model_step(rst, st);
    #1;
    compare_all();
    if (o_wr_acc)  wr_acc_cnt++;
    if (o_wr_ram)  wr_ram_cnt++;
    if (o_illegal) ill_cnt++;
    i_instr = rom[prev_pc];
    prev_pc = o_pc;
    i_reset = 1'b0;
    i_start = 1'b0;
  endtask

  task automatic clear_counts();
    wr_acc_cnt = 0; wr_ram_cnt = 0; ill_cnt = 0;
  endtask

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_instr = 16'h0000; prev_pc = 11'd0;
    m_mode = 0; m_phase = 0; m_pc = 0; m_op = 0; m_opr = 0;
    clear_counts();
    for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;

    // Reset state, and start held off while reset is asserted.
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);

    // LDI 5, ADDI 3, SUB 0x002, HLT; start pulsed during FETCH and during HALT.
    rom[0] = ins(3, 5); rom[1] = ins(5, 3); rom[2] = ins(6, 2); rom[3] = ins(0, 0);
    step(1'b1, 1'b0);
    clear_counts();
    step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, (i == 0) || (i == 17));
    check_eq("prog1_wr_acc_pulses", 32'(wr_acc_cnt), 32'd3);
    check_eq("prog1_halt", 32'(o_halt), 32'd1);
    check_eq("prog1_pc_frozen", 32'(o_pc), 32'd3);

    // STO 0x010, an undefined opcode, then HLT.
    rom[0] = ins(1, 16'h010); rom[1] = ins(31, 5); rom[2] = ins(0, 0);
    step(1'b1, 1'b0);
    clear_counts();
    step(1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0);
    check_eq("sto_wr_ram_pulses", 32'(wr_ram_cnt), 32'd1);
    check_eq("sto_wr_acc_pulses", 32'(wr_acc_cnt), 32'd0);
    check_eq("illegal_pulses", 32'(ill_cnt), 32'd1);
    check_eq("illegal_pc_after", 32'(o_pc), 32'd2);

    // Reset landing in the EXEC cycle of ADD.
    rom[0] = ins(4, 7); rom[1] = ins(0, 0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_eq("add_exec_wr_acc", 32'(o_wr_acc), 32'd1);
    step(1'b1, 1'b0);
    check_eq("rst_exec_wr_acc", 32'(o_wr_acc), 32'd0);
    check_eq("rst_exec_busy", 32'(o_busy), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check_eq("rst_exec_idle", 32'(o_busy), 32'd0);

    // PC wrap: every word undefined, run one full pass plus one cycle.
    for (int i = 0; i < 2048; i++) rom[i] = ins(8 + (i % 24), i);
    step(1'b1, 1'b0);
    clear_counts();
    step(1'b0, 1'b1);
    for (int i = 0; i < 2048 * 3 + 1; i++) step(1'b0, 1'b0);
    check_eq("wrap_illegal_pulses", 32'(ill_cnt), 32'd2048);
    check_eq("wrap_pc", 32'(o_pc), 32'd0);

    // Random programs with random resets and start pulses.
    for (int i = 0; i < 2048; i++) begin
      int op;
      op = int'($urandom_range(0, 31));
      if (op == 0 && $urandom_range(0, 3) != 0) op = 1 + int'($urandom_range(0, 6));
      rom[i] = ins(op, int'($urandom_range(0, 2047)));
    end
    step(1'b1, 1'b0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
